// File: rtl/load_store_unit.sv
// Load/store bus initiator: one request at a time, word-wide memory port,
// sub-word stores done as read-modify-write, loads returned aligned and extended.

module lsu_lane (
   input  logic       sel,
   input  logic [7:0] rd,
   input  logic [7:0] wd,
   output logic [7:0] q
);
   assign q = sel ? wd : rd;
endmodule

module load_store_unit #(
   parameter int ADDR_W       = 10,
   parameter int READ_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_error,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   input  logic [31:0]       mem_readword
);
   localparam int NUM_LANES = 4;
   localparam int CNT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t                         state;
   logic [CNT_W-1:0]               cnt;
   logic                           store_q;
   logic [1:0]                     size_q;
   logic                           uns_q;
   logic [1:0]                     addr_lo;
   logic [15:0]                    wdata_q;

   logic                           acc_err;
   logic [NUM_LANES-1:0]           lane_sel;
   logic [NUM_LANES-1:0][7:0]      lane_wd;
   logic [NUM_LANES-1:0][7:0]      merged;
   logic [7:0]                     ld_b;
   logic [15:0]                    ld_h;
   logic [31:0]                    ld_data;

   assign req_ready = (state == IDLE) && !reset;

   assign acc_err = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   // Byte store replicates wdata[7:0] to every lane; half store alternates the two halves.
   generate
      for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
         assign lane_sel[k] = size_q[0] ? (addr_lo[1] == 1'(k / 2)) : (addr_lo == 2'(k));
         assign lane_wd[k]  = size_q[0] ? wdata_q[8*(k%2) +: 8] : wdata_q[7:0];
         lsu_lane u_lane (
            .sel (lane_sel[k]),
            .rd  (mem_readword[8*k +: 8]),
            .wd  (lane_wd[k]),
            .q   (merged[k])
         );
      end
   endgenerate

   assign ld_b = mem_readword[{addr_lo, 3'b000} +: 8];
   assign ld_h = mem_readword[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      ld_data = mem_readword;
      case (size_q)
         2'b00:   ld_data = uns_q ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
         2'b01:   ld_data = uns_q ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
         default: ld_data = mem_readword;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         store_q       <= 1'b0;
         size_q        <= 2'b00;
         uns_q         <= 1'b0;
         addr_lo       <= 2'b00;
         wdata_q       <= '0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_error     <= 1'b0;
         mem_address   <= '0;
         mem_write     <= 1'b0;
         mem_writedata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  store_q <= req_store;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  addr_lo <= req_addr[1:0];
                  wdata_q <= req_wdata[15:0];
                  if (acc_err) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_error <= 1'b1;
                     rsp_rdata <= '0;
                  end else if (req_store && req_size == 2'b10) begin
                     state         <= WRITE;
                     mem_address   <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_write     <= 1'b1;
                     mem_writedata <= req_wdata;
                  end else begin
                     state       <= READ;
                     mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
                     cnt         <= CNT_W'(READ_LATENCY - 1);
                  end
               end
            end
            READ: begin
               if (cnt == '0) begin
                  if (store_q) begin
                     state         <= WRITE;
                     mem_write     <= 1'b1;
                     mem_writedata <= merged;
                  end else begin
                     state       <= RESP;
                     mem_address <= '0;
                     rsp_valid   <= 1'b1;
                     rsp_rdata   <= ld_data;
                     rsp_error   <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WRITE: begin
               state         <= RESP;
               mem_address   <= '0;
               mem_write     <= 1'b0;
               mem_writedata <= '0;
               rsp_valid     <= 1'b1;
               rsp_rdata     <= '0;
               rsp_error     <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_error <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a word memory (RL=1, read data combinational)
// and a per-cycle reference model of every output.

module tb_load_store_unit;
   localparam int RL = 1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [9:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [9:0]  mem_address;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readword;

   int tests = 0;
   int fails = 0;

   load_store_unit #(.ADDR_W(10), .READ_LATENCY(RL)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .mem_address(mem_address), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_readword(mem_readword)
   );

   always #5 clock = ~clock;

   // data memory
   logic [31:0] mem [0:255] = '{default: 32'h0};
   assign mem_readword = mem[mem_address[9:2]];
   always @(posedge clock) if (mem_write) mem[mem_address[9:2]] <= mem_writedata;

   typedef struct packed {
      logic        ready;
      logic [9:0]  addr;
      logic        wr;
      logic [31:0] wd;
      logic        rv;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t        expq[$];
   logic [31:0] ref_mem [0:255] = '{default: 32'h0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: expand an accepted request into its expected per-cycle outputs.
   task automatic model_accept();
      exp_t        e;
      logic [31:0] w, v, mask;
      int          sh;
      logic        err;
      err = (req_size == 3) || (req_size == 1 && req_addr[0]) ||
            (req_size == 2 && req_addr[1:0] != 0);
      e = '0;
      if (err) begin
         e.rv = 1; e.err = 1; expq.push_back(e);
         return;
      end
      if (req_store && req_size == 2) begin
         e.addr = req_addr & 10'h3FC; e.wr = 1; e.wd = req_wdata; expq.push_back(e);
         e = '0; e.rv = 1; expq.push_back(e);
         return;
      end
      w = ref_mem[req_addr[9:2]];
      for (int i = 0; i < RL; i++) begin
         e = '0; e.addr = req_addr & 10'h3FC; expq.push_back(e);
      end
      if (req_store) begin
         sh   = (req_size == 0) ? 8 * req_addr[1:0] : 16 * req_addr[1];
         mask = ((req_size == 0) ? 32'hFF : 32'hFFFF) << sh;
         v    = (w & ~mask) | ((req_wdata << sh) & mask);
         e = '0; e.addr = req_addr & 10'h3FC; e.wr = 1; e.wd = v; expq.push_back(e);
         e = '0; e.rv = 1; expq.push_back(e);
      end else begin
         if (req_size == 0) begin
            v = (w >> (8 * req_addr[1:0])) & 32'hFF;
            if (!req_unsigned && v >= 32'h80) v = v - 32'h100;
         end else if (req_size == 1) begin
            v = (w >> (16 * req_addr[1])) & 32'hFFFF;
            if (!req_unsigned && v >= 32'h8000) v = v - 32'h10000;
         end else v = w;
         e = '0; e.rv = 1; e.rd = v; expq.push_back(e);
      end
   endtask

   task automatic do_op(input string nm, input logic st, input logic [1:0] sz, input logic un,
                        input logic [9:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat, input logic hold);
      int lat;
      int tmo;
      @(negedge clock);
      req_valid = 1; req_store = st; req_size = sz; req_unsigned = un;
      req_addr = a; req_wdata = wd;
      tmo = 0;
      while (!req_ready && tmo < 20) begin @(negedge clock); tmo++; end
      if (tmo >= 20) begin
         fails++; tests++;
         $display("FAIL %s_ready: timeout waiting for req_ready", nm);
      end
      @(posedge clock);
      #1 req_valid = hold;
      lat = 0;
      while (lat < 20) begin
         @(negedge clock);
         lat++;
         if (lat >= 2) req_valid = 0;
         if (rsp_valid) break;
      end
      req_valid = 0;
      chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({nm, "_rdata"}, rsp_rdata, exp_rd);
      chk({nm, "_err"}, {31'h0, rsp_error}, {31'h0, exp_err});
   endtask

   initial begin
      fork
         forever begin
            @(posedge clock);
            if (!reset && req_valid && expq.size() == 0) model_accept();
         end
         forever begin
            exp_t e;
            @(negedge clock);
            e = '0;
            if (reset) expq.delete();
            else if (expq.size() != 0) e = expq.pop_front();
            else e.ready = 1;
            chk("cyc_ready", {31'h0, req_ready}, {31'h0, e.ready});
            chk("cyc_addr", {22'h0, mem_address}, {22'h0, e.addr});
            chk("cyc_write", {31'h0, mem_write}, {31'h0, e.wr});
            chk("cyc_wdata", mem_writedata, e.wd);
            chk("cyc_rvalid", {31'h0, rsp_valid}, {31'h0, e.rv});
            chk("cyc_rdata", rsp_rdata, e.rd);
            chk("cyc_rerr", {31'h0, rsp_error}, {31'h0, e.err});
            if (e.wr) ref_mem[e.addr[9:2]] = e.wd;
         end
      join_none

      repeat (2) @(negedge clock);
      chk("rst_ready", {31'h0, req_ready}, 32'h0);
      chk("rst_write", {31'h0, mem_write}, 32'h0);
      chk("rst_rvalid", {31'h0, rsp_valid}, 32'h0);
      #2 reset = 0;

      do_op("sw0",  1, 2, 0, 10'h000, 32'h0BADF00D, 32'h0,        0, 2, 0);
      do_op("lw0",  0, 2, 0, 10'h000, 32'h0,        32'h0BADF00D, 0, 2, 0);
      do_op("sw4",  1, 2, 0, 10'h004, 32'hABC56F33, 32'h0,        0, 2, 0);
      do_op("sb6",  1, 0, 0, 10'h006, 32'h0000007E, 32'h0,        0, 3, 0);
      chk("mem1_sb", mem[1], 32'hAB7E6F33);
      do_op("lw4",  0, 2, 0, 10'h004, 32'h0,        32'hAB7E6F33, 0, 2, 0);
      do_op("lb7",  0, 0, 0, 10'h007, 32'h0,        32'hFFFFFFAB, 0, 2, 0);
      do_op("lbu7", 0, 0, 1, 10'h007, 32'h0,        32'h000000AB, 0, 2, 0);
      do_op("lh2",  0, 1, 0, 10'h002, 32'h0,        32'h00000BAD, 0, 2, 0);
      do_op("lh0",  0, 1, 0, 10'h000, 32'h0,        32'hFFFFF00D, 0, 2, 0);
      do_op("lhu0", 0, 1, 1, 10'h000, 32'h0,        32'h0000F00D, 0, 2, 0);
      do_op("sh2",  1, 1, 0, 10'h002, 32'hFFFF1234, 32'h0,        0, 3, 0);
      chk("mem0_sh", mem[0], 32'h1234F00D);
      do_op("elw1", 0, 2, 0, 10'h001, 32'h0,        32'h0,        1, 1, 0);
      do_op("esh3", 1, 1, 0, 10'h003, 32'h00005678, 32'h0,        1, 1, 0);
      do_op("esz3", 1, 3, 0, 10'h008, 32'h11111111, 32'h0,        1, 1, 0);
      chk("mem0_err", mem[0], 32'h1234F00D);
      chk("mem2_err", mem[2], 32'h0);
      do_op("swtop", 1, 2, 0, 10'h3FC, 32'hCAFEBABE, 32'h0,        0, 2, 0);
      do_op("lbutop",0, 0, 1, 10'h3FF, 32'h0,        32'h000000CA, 0, 2, 0);
      do_op("sbtop", 1, 0, 0, 10'h3FF, 32'h00000055, 32'h0,        0, 3, 0);
      do_op("lwtop", 0, 2, 0, 10'h3FC, 32'h0,        32'h55FEBABE, 0, 2, 0);
      do_op("swhold",1, 2, 0, 10'h00C, 32'h13579BDF, 32'h0,        0, 2, 1);
      do_op("lwhold",0, 2, 0, 10'h00C, 32'h0,        32'h13579BDF, 0, 2, 0);

      // reset during the read phase of a byte store
      @(negedge clock);
      req_valid = 1; req_store = 1; req_size = 0; req_addr = 10'h005; req_wdata = 32'h99;
      @(posedge clock);
      #1 req_valid = 0;
      #2 reset = 1;
      @(negedge clock);
      @(negedge clock);
      #2 reset = 0;
      @(negedge clock);
      chk("ready_after_rst", {31'h0, req_ready}, 32'h1);
      chk("mem1_rst", mem[1], 32'hAB7E6F33);

      // reset during the write cycle of a word store
      @(negedge clock);
      req_valid = 1; req_store = 1; req_size = 2; req_addr = 10'h010; req_wdata = 32'hDEADBEEF;
      @(posedge clock);
      #1 req_valid = 0;
      reset = 1;
      #1 chk("wr_drop", {31'h0, mem_write}, 32'h0);
      @(negedge clock);
      #2 reset = 0;
      @(negedge clock);
      chk("mem4_rst", mem[4], 32'h0);
      do_op("lwpost", 0, 2, 0, 10'h004, 32'h0,       32'hAB7E6F33, 0, 2, 0);
      repeat (2) @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
